// File: rtl/enc2_arbiter.sv
// enc2_arbiter: round-robin scheduler sharing one encrypt_function_2 core among NREQ requesters
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   req_valid/req_data  : per-requester 60-bit plaintext handshake, req_ready one-hot accept
//   core_data/rand_11/6 : registered inputs to the core, core_outEnc its registered result
//   out_valid/out_ready : ciphertext handshake carrying out_data and originating out_id
//   busy, err           : not idle, sticky key-echo mismatch
module enc2_arbiter #(
  parameter int NREQ = 4,
  parameter logic [10:0] SEED11 = 11'h5A5,
  parameter logic [5:0] SEED6 = 6'h2D,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*60-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [59:0]        core_data,
  output logic [10:0]        core_rand_11,
  output logic [5:0]         core_rand_6,
  input  logic [77:0]        core_outEnc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [77:0]        out_data,
  output logic [IDW-1:0]     out_id,
  output logic               busy,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUTPUT} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, gidx, j;
  logic [10:0] lfsr11;
  logic [5:0] lfsr6;
  logic found;
  logic [59:0] words [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[60*g +: 60];
  end
  assign busy = state != IDLE;
  // First valid requester at or after rr_ptr wins; grants are suppressed outside IDLE and during reset.
  always_comb begin
    gidx = '0;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gidx = j;
      end
    end
    if (state != IDLE || !Rst_n) found = 1'b0;
    req_ready = found ? NREQ'(1) << gidx : '0;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      lfsr11 <= SEED11;
      lfsr6 <= SEED6;
      core_data <= '0;
      core_rand_11 <= '0;
      core_rand_6 <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (found) begin
          core_data <= words[gidx];
          core_rand_11 <= lfsr11;
          core_rand_6 <= lfsr6;
          out_id <= gidx;
          rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          lfsr11 <= {lfsr11[9:0], lfsr11[10] ^ lfsr11[8]};
          lfsr6 <= {lfsr6[4:0], lfsr6[5] ^ lfsr6[4]};
          state <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          out_data <= core_outEnc;
          out_valid <= 1'b1;
          err <= err | (core_outEnc[77:67] != core_rand_11) | (core_outEnc[5:0] != core_rand_6);
          state <= OUTPUT;
        end
        OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_enc2_arbiter.sv
// tb_enc2_arbiter: directed self-checking bench for enc2_arbiter with a behavioural core
module tb_enc2_arbiter;
  logic Clk = 1'b0;
  logic Rst_n;
  logic [3:0] req_valid;
  logic [239:0] req_data;
  logic [3:0] req_ready;
  logic [59:0] core_data;
  logic [10:0] core_rand_11;
  logic [5:0] core_rand_6;
  logic [77:0] core_outEnc;
  logic out_valid, out_ready, busy, err;
  logic [77:0] out_data;
  logic [1:0] out_id;
  logic corrupt;
  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp11, last11;
  logic [5:0] exp6, last6;
  logic exp_err;

  enc2_arbiter #(.NREQ(4), .SEED11(11'h5A5), .SEED6(6'h2D)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .core_data(core_data), .core_rand_11(core_rand_11), .core_rand_6(core_rand_6),
    .core_outEnc(core_outEnc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy), .err(err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [59:0] bfn(input logic [10:0] r);
    return {r[4:0], r, ~r, ~r, r, r};
  endfunction

  function automatic logic [77:0] golden(input logic [59:0] d, input logic [10:0] r, input logic [5:0] r6);
    logic [60:0] s;
    s = {1'b0, d} + {1'b0, bfn(r)};
    return {r, s, r6};
  endfunction

  function automatic logic [10:0] nx11(input logic [10:0] q);
    return {q[9:0], q[10] ^ q[8]};
  endfunction

  function automatic logic [5:0] nx6(input logic [5:0] q);
    return {q[4:0], q[5] ^ q[4]};
  endfunction

  // Core stand-in: one registered cycle, echoes keys, optional bit-0 corruption
  always @(posedge Clk) core_outEnc <= golden(core_data, core_rand_11, core_rand_6) ^ {77'b0, corrupt};

  task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    exp11 = 11'h5A5;
    exp6 = 6'h2D;
    exp_err = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  task automatic serve(input int id, input logic [59:0] d, input int hold, input bit drop);
    logic [77:0] eo;
    for (int i = 0; i < 60; i++) req_data[60*id + i] = d[i];
    req_valid[id] = 1'b1;
    out_ready = (hold == 0);
    #1;
    chk("grant", {74'b0, req_ready}, 78'(4'b0001 << id));
    eo = golden(d, exp11, exp6) ^ {77'b0, corrupt};
    @(posedge Clk); #1;
    if (drop) req_valid[id] = 1'b0;
    last11 = core_rand_11;
    last6 = core_rand_6;
    chk("core_data", {18'b0, core_data}, {18'b0, d});
    chk("rand_11", {67'b0, core_rand_11}, {67'b0, exp11});
    chk("rand_6", {72'b0, core_rand_6}, {72'b0, exp6});
    chk("busy", {77'b0, busy}, 78'd1);
    chk("ready_issue", {74'b0, req_ready}, 78'd0);
    exp11 = nx11(exp11);
    exp6 = nx6(exp6);
    @(posedge Clk); #1;
    chk("valid_early", {77'b0, out_valid}, 78'd0);
    @(posedge Clk); #1;
    if (corrupt) exp_err = 1'b1;
    chk("out_valid", {77'b0, out_valid}, 78'd1);
    chk("out_data", out_data, eo);
    chk("out_id", {76'b0, out_id}, 78'(id));
    chk("err", {77'b0, err}, {77'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("hold_valid", {77'b0, out_valid}, 78'd1);
      chk("hold_data", out_data, eo);
      chk("hold_id", {76'b0, out_id}, 78'(id));
      chk("hold_ready", {74'b0, req_ready}, 78'd0);
    end
    out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("valid_clear", {77'b0, out_valid}, 78'd0);
    chk("idle", {77'b0, busy}, 78'd0);
  endtask

  initial begin
    Rst_n = 1'b0;
    req_valid = 4'hF;
    req_data = '0;
    out_ready = 1'b0;
    corrupt = 1'b0;
    exp11 = 11'h5A5;
    exp6 = 6'h2D;
    exp_err = 1'b0;
    last11 = '0;
    last6 = '0;
    #12;
    chk("rst_ready", {74'b0, req_ready}, 78'd0);
    chk("rst_valid", {77'b0, out_valid}, 78'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    #1;
    chk("rel_ready", {74'b0, req_ready}, 78'b0001);
    chk("rel_valid", {77'b0, out_valid}, 78'd0);
    chk("rel_err", {77'b0, err}, 78'd0);
    chk("rel_busy", {77'b0, busy}, 78'd0);
    chk("rel_core", {core_data, core_rand_11, core_rand_6, 1'b0}, 78'd0);
    chk("rel_out", out_data, 78'd0);
    req_valid = 4'h0;
    @(posedge Clk); #1;

    serve(2, 60'h0, 0, 1'b1);
    chk("single_word", out_data, {11'h5A5, 1'b0, bfn(11'h5A5), 6'h2D});
    serve(2, 60'h123_4567_89AB_CDEF, 0, 1'b1);
    chk("lfsr11_step", {67'b0, last11}, 78'h34A);
    chk("lfsr6_step", {72'b0, last6}, 78'h1B);

    do_reset();
    for (int i = 0; i < 4; i++) req_data[60*i +: 60] = 60'h0A0_0000_0000_0000 + 60'(i);
    req_valid = 4'hF;
    serve(0, 60'h0A0_0000_0000_0000, 0, 1'b0);
    serve(1, 60'h0A0_0000_0000_0001, 0, 1'b0);
    serve(2, 60'h0A0_0000_0000_0002, 0, 1'b0);
    serve(3, 60'h0A0_0000_0000_0003, 0, 1'b0);
    serve(0, 60'h0A0_0000_0000_0000, 0, 1'b0);
    req_valid = 4'h0;

    do_reset();
    serve(1, 60'hFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    chk("carry", {77'b0, out_data[66]}, 78'd1);

    req_data[180 +: 60] = 60'h333_3333_3333_3333;
    req_valid[3] = 1'b1;
    serve(2, 60'h5A5_A5A5_A5A5_A5A5, 10, 1'b1);
    serve(3, 60'h333_3333_3333_3333, 0, 1'b1);

    do_reset();
    req_data[0 +: 60] = 60'hABC_DEF0_1234_5678;
    req_valid[0] = 1'b1;
    #1;
    @(posedge Clk); #1;
    req_valid[0] = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    chk("mid_valid", {77'b0, out_valid}, 78'd0);
    chk("mid_busy", {77'b0, busy}, 78'd0);
    chk("mid_core", {67'b0, core_rand_11}, 78'd0);
    exp11 = 11'h5A5;
    exp6 = 6'h2D;
    @(posedge Clk); #1 Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("mid_quiet", {77'b0, out_valid}, 78'd0);
    end
    serve(0, 60'h777_0000_1111_2222, 0, 1'b1);
    chk("mid_seed", {67'b0, last11}, 78'h5A5);

    corrupt = 1'b1;
    serve(1, 60'h0F0_F0F0_F0F0_F0F0, 0, 1'b1);
    corrupt = 1'b0;
    chk("err_set", {77'b0, err}, 78'd1);
    serve(2, 60'h00F_0F0F_0F0F_0F0F, 0, 1'b1);
    chk("err_sticky", {77'b0, err}, 78'd1);
    do_reset();
    chk("err_clear", {77'b0, err}, 78'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
